// File: rtl/bnn_frame_ctrl.sv
// bnn_frame_ctrl: host-side frame controller for the BNN accelerator.
// Each cs_n frame opens with one command byte:
//   0xA5 load image, 0x5A read result, 0xC3 clear.
// A load streams the packed 1-bit image into the buffer and then starts the
// engine. Inter-byte timeouts, short frames and bad commands latch sticky
// error flags. Only a clear command or rst resets those flags.
// Optional macro CHECKSUM_EN: the load ends with one extra XOR checksum byte.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cs_n, rx_valid, rx_data      synchronised SPI select and received byte strobe
//   tx_data                      next byte to shift out (result or status)
//   buf_we/addr/wdata            image buffer write port
//   buf_clear, buf_clear_done    buffer clear request/acknowledge
//   infer_start/done/class       inference engine handshake
//   result_valid, state_o        result register valid, current state
//   err_timeout/frame/cksum      sticky error flags
//
// state   | meaning
// IDLE    | waiting for cs_n low
// CMD     | waiting for the command byte
// LOAD    | streaming image bytes (and checksum) into the buffer
// INFER   | engine started, waiting for infer_done
// RESULT  | result byte presented on tx_data until cs_n rises
// CLEAR   | buffer clear requested, waiting for buf_clear_done
// WAIT_CS | operation finished, waiting for cs_n high
// ERROR   | frame aborted, waiting for cs_n high
module bnn_frame_ctrl #(
   parameter int IMG_W          = 28,
   parameter int IMG_H          = 28,
   parameter int CLASS_W        = 4,
   parameter int TIMEOUT_CYCLES = 100000,
   localparam int NBYTES        = (IMG_W * IMG_H + 7) / 8,
   localparam int ADDR_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cs_n,
   input  logic               rx_valid,
   input  logic [7:0]         rx_data,
   output logic [7:0]         tx_data,
   output logic               buf_we,
   output logic [ADDR_W-1:0]  buf_addr,
   output logic [7:0]         buf_wdata,
   output logic               buf_clear,
   input  logic               buf_clear_done,
   output logic               infer_start,
   input  logic               infer_done,
   input  logic [CLASS_W-1:0] infer_class,
   output logic               result_valid,
   output logic [2:0]         state_o,
   output logic               err_timeout,
   output logic               err_frame,
   output logic               err_cksum
);

   localparam int CNT_W = $clog2(NBYTES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_NB  = CNT_W'(NBYTES);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`ifndef CHECKSUM_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_CMD = 3'd1, S_LOAD = 3'd2, S_INFER = 3'd3,
      S_RESULT = 3'd4, S_CLEAR = 3'd5, S_WAIT_CS = 3'd6, S_ERROR = 3'd7
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [TO_W-1:0]      tout_q, tout_d;
   logic                 first_q, first_d;
   logic [CLASS_W-1:0]   result_q, result_d;
   logic                 rv_q, rv_d;
   logic                 err_t_q, err_t_d, err_f_q, err_f_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 go_frame, go_timeout;
   logic [7:0]           res_byte;
`ifdef CHECKSUM_EN
   logic                 err_c_q, err_c_d, go_cksum;
   logic [7:0]           cksum_q, cksum_d;
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d    = state_q;
      go_frame   = 1'b0;
      go_timeout = 1'b0;
`ifdef CHECKSUM_EN
      go_cksum   = 1'b0;
`endif
      case (state_q)
         S_IDLE: if (!cs_n) state_d = S_CMD;
         S_CMD: begin
            if (cs_n) state_d = S_IDLE;
            else if (rx_valid) begin
               case (rx_data)
                  8'hA5:   state_d = S_LOAD;
                  8'h5A:   state_d = S_RESULT;
                  8'hC3:   state_d = S_CLEAR;
                  default: begin state_d = S_ERROR; go_frame = 1'b1; end
               endcase
            end
         end
         S_LOAD: begin
            // A byte arriving with the cs_n rise is accepted first, so a
            // completed image (or checksum) wins over the short-frame error.
`ifdef CHECKSUM_EN
            if (rx_valid && count_q == CNT_NB) begin
               if (rx_data == cksum_q) state_d = S_INFER;
               else begin state_d = S_ERROR; go_cksum = 1'b1; end
            end else
`else
            if (rx_valid && count_q == CNT_LAST) state_d = S_INFER;
            else
`endif
            if (cs_n) begin
               state_d  = S_ERROR;
               go_frame = 1'b1;
            end else if (!rx_valid && tout_q == TO_LAST) begin
               state_d    = S_ERROR;
               go_timeout = 1'b1;
            end
         end
         S_INFER:  if (!first_q && infer_done) state_d = S_WAIT_CS;
         S_CLEAR:  if (buf_clear_done) state_d = S_WAIT_CS;
         S_RESULT, S_WAIT_CS, S_ERROR: if (cs_n) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // datapath next values
   always_comb begin
      count_d  = count_q;
      tout_d   = tout_q;
      result_d = result_q;
      rv_d     = rv_q;
      err_t_d  = err_t_q | go_timeout;
      err_f_d  = err_f_q | go_frame;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      first_d  = (state_d == S_INFER) && (state_q != S_INFER);
`ifdef CHECKSUM_EN
      err_c_d  = err_c_q | go_cksum;
      cksum_d  = cksum_q;
`endif
      if (state_q == S_CMD && state_d == S_LOAD) begin
         count_d = '0;
         tout_d  = '0;
         rv_d    = 1'b0;
`ifdef CHECKSUM_EN
         cksum_d = '0;
`endif
      end
      if (state_q == S_LOAD) begin
         if (rx_valid) begin
            tout_d = '0;
            // the checksum byte (count == NBYTES) is never written
            if (count_q < CNT_NB) begin
               we_d    = 1'b1;
               addr_d  = count_q[ADDR_W-1:0];
               wdata_d = rx_data;
               count_d = count_q + 1'b1;
`ifdef CHECKSUM_EN
               cksum_d = cksum_q ^ rx_data;
`endif
            end
         end else begin
            tout_d = tout_q + 1'b1;
         end
      end
      if (state_q == S_INFER && !first_q && infer_done) begin
         result_d = infer_class;
         rv_d     = 1'b1;
      end
      if (state_q == S_CLEAR && buf_clear_done) begin
         rv_d    = 1'b0;
         err_t_d = 1'b0;
         err_f_d = 1'b0;
`ifdef CHECKSUM_EN
         err_c_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         tout_q   <= '0;
         first_q  <= 1'b0;
         result_q <= '0;
         rv_q     <= 1'b0;
         err_t_q  <= 1'b0;
         err_f_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
`ifdef CHECKSUM_EN
         err_c_q  <= 1'b0;
         cksum_q  <= '0;
`endif
      end else begin
         count_q  <= count_d;
         tout_q   <= tout_d;
         first_q  <= first_d;
         result_q <= result_d;
         rv_q     <= rv_d;
         err_t_q  <= err_t_d;
         err_f_q  <= err_f_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
`ifdef CHECKSUM_EN
         err_c_q  <= err_c_d;
         cksum_q  <= cksum_d;
`endif
      end
   end

`ifdef CHECKSUM_EN
   assign err_cksum = err_c_q;
`else
   assign err_cksum = 1'b0;
`endif
   assign err_timeout  = err_t_q;
   assign err_frame    = err_f_q;
   assign result_valid = rv_q;
   assign buf_we       = we_q;
   assign buf_addr     = addr_q;
   assign buf_wdata    = wdata_q;

   // outputs
   always_comb begin
      state_o     = state_q;
      infer_start = (state_q == S_INFER) && first_q;
      buf_clear   = (state_q == S_CLEAR) && !buf_clear_done;
      res_byte    = '0;
      res_byte[7] = rv_q;
      res_byte[CLASS_W-1:0] = result_q;
      if (state_q == S_RESULT) tx_data = res_byte;
      else tx_data = {state_q, 2'b00, err_t_q, err_f_q, err_cksum};
   end

endmodule

// File: tb/tb_bnn_frame_ctrl.sv
// Randomised frame-level bench for bnn_frame_ctrl. Expected values come from
// the frame rules: byte lists, XOR of the image, cycle counts and flag bits
// kept as plain variables.
module tb_bnn_frame_ctrl;
`ifdef CHECKSUM_EN
   localparam int  IW = 4, IH = 4;
   localparam bit  CK = 1'b1;
`else
   localparam int  IW = 28, IH = 28;
   localparam bit  CK = 1'b0;
`endif
   localparam int CW = 4;
   localparam int TO = 50;
   localparam int NB = (IW * IH + 7) / 8;
   localparam int AW = ($clog2(NB) > 0) ? $clog2(NB) : 1;
   localparam int S_IDLE = 0, S_CMD = 1, S_LOAD = 2, S_INFER = 3, S_RESULT = 4,
                  S_CLEAR = 5, S_WAIT_CS = 6, S_ERROR = 7;

   logic          clk, rst, cs_n, rx_valid, buf_clear_done, infer_done;
   logic [7:0]    rx_data, tx_data, buf_wdata;
   logic          buf_we, buf_clear, infer_start, result_valid;
   logic [AW-1:0] buf_addr;
   logic [CW-1:0] infer_class;
   logic [2:0]    state_o;
   logic          err_timeout, err_frame, err_cksum;

   bnn_frame_ctrl #(.IMG_W(IW), .IMG_H(IH), .CLASS_W(CW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_data(tx_data), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
      .buf_clear(buf_clear), .buf_clear_done(buf_clear_done),
      .infer_start(infer_start), .infer_done(infer_done), .infer_class(infer_class),
      .result_valid(result_valid), .state_o(state_o),
      .err_timeout(err_timeout), .err_frame(err_frame), .err_cksum(err_cksum));

   int checks = 0, errors = 0;
   logic [7:0]    img [NB];
   logic [7:0]    wr_data [$];
   int unsigned   wr_addr [$];
   int            start_cnt;
   logic          exp_rv, exp_et, exp_ef, exp_ec;
   logic [CW-1:0] exp_class;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (buf_we) begin
         wr_data.push_back(buf_wdata);
         wr_addr.push_back(int'(buf_addr));
      end
      if (infer_start) start_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] st_byte(input int s);
      return {3'(s), 2'b00, exp_et, exp_ef, exp_ec};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic smp();
      @(negedge clk); #1;
   endtask

   task automatic send(input logic [7:0] b, input bit rise);
      rx_valid = 1'b1;
      rx_data  = b;
      if (rise) cs_n = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic check_writes(input int n);
      chk("wr_cnt", wr_data.size(), n);
      for (int i = 0; i < n && i < wr_data.size(); i++) begin
         chk("wr_addr", wr_addr[i], i);
         chk("wr_data", wr_data[i], img[i]);
      end
   endtask

   // sends the command and nsend image bytes; a full image in the checksum
   // build is followed by the checksum (corrupted when bad_ck)
   task automatic do_load(input int nsend, input bit rise_last, input bit bad_ck);
      logic [7:0] x;
      wr_data.delete();
      wr_addr.delete();
      start_cnt = 0;
      cs_n = 1'b0;
      tick(1);
      send(8'hA5, 1'b0);
      smp();
      chk("ld_entry", state_o, S_LOAD);
      chk("ld_rv0", result_valid, 0);
      exp_rv = 1'b0;
      x = 8'h00;
      for (int i = 0; i < nsend; i++) begin
         img[i] = 8'($urandom);
         x = x ^ img[i];
         send(img[i], rise_last && !CK && (i == nsend - 1));
         if (i != nsend - 1) tick($urandom_range(0, 3));
      end
      if (CK && nsend == NB) begin
         tick($urandom_range(0, 3));
         send(bad_ck ? (x ^ 8'($urandom_range(1, 255))) : x, rise_last);
      end
   endtask

   task automatic full_load(input bit rise_last, input bit bad_ck);
      logic [CW-1:0] cls;
      do_load(NB, rise_last, bad_ck);
      smp();
      chk("ld_state", state_o, bad_ck ? S_ERROR : S_INFER);
      chk("ld_start", infer_start, !bad_ck);
      if (bad_ck) exp_ec = 1'b1;
      chk("ld_ecks", err_cksum, exp_ec);
      chk("ld_status", tx_data, st_byte(bad_ck ? S_ERROR : S_INFER));
      infer_done  = 1'b1;
      infer_class = CW'($urandom);
      tick(1);
      infer_done = 1'b0;
      check_writes(NB);
      if (!bad_ck) begin
         chk("inf_hold", state_o, S_INFER);
         chk("inf_rv0", result_valid, 0);
         tick($urandom_range(0, 4));
         cls = CW'($urandom);
         infer_done  = 1'b1;
         infer_class = cls;
         tick(1);
         infer_done = 1'b0;
         exp_rv = 1'b1;
         exp_class = cls;
         smp();
         chk("inf_wait", state_o, S_WAIT_CS);
         chk("inf_rv", result_valid, exp_rv);
      end
      chk("start_cnt", start_cnt, !bad_ck);
      cs_n = 1'b1;
      tick(1);
      smp();
      chk("ld_idle", state_o, S_IDLE);
   endtask

   task automatic read_result();
      cs_n = 1'b0;
      tick(1);
      send(8'h5A, 1'b0);
      smp();
      chk("rd_state", state_o, S_RESULT);
      chk("rd_tx", tx_data, (int'(exp_rv) << 7) | int'(exp_class));
      send(8'($urandom), 1'b0);
      smp();
      chk("rd_hold", state_o, S_RESULT);
      cs_n = 1'b1;
      tick(1);
      smp();
      chk("rd_idle", state_o, S_IDLE);
      chk("rd_status", tx_data, st_byte(S_IDLE));
   endtask

   task automatic short_load(input int k);
      do_load(k, 1'b0, 1'b0);
      tick($urandom_range(0, 3));
      cs_n = 1'b1;
      tick(1);
      smp();
      exp_ef = 1'b1;
      chk("sh_state", state_o, S_ERROR);
      chk("sh_eframe", err_frame, exp_ef);
      chk("sh_status", tx_data, st_byte(S_ERROR));
      check_writes(k);
      chk("sh_start", start_cnt, 0);
      tick(1);
      smp();
      chk("sh_idle", state_o, S_IDLE);
   endtask

   task automatic to_load(input int k);
      do_load(k, 1'b0, 1'b0);
      tick(TO - 1);
      smp();
      chk("to_before", state_o, S_LOAD);
      chk("to_et0", err_timeout, exp_et);
      tick(1);
      smp();
      exp_et = 1'b1;
      chk("to_state", state_o, S_ERROR);
      chk("to_et", err_timeout, exp_et);
      chk("to_status", tx_data, st_byte(S_ERROR));
      check_writes(k);
      chk("to_start", start_cnt, 0);
      cs_n = 1'b1;
      tick(1);
      smp();
      chk("to_idle", state_o, S_IDLE);
   endtask

   task automatic cmd_bad(input logic [7:0] b);
      cs_n = 1'b0;
      tick(1);
      send(b, 1'b0);
      smp();
      exp_ef = 1'b1;
      chk("cmd_state", state_o, S_ERROR);
      chk("cmd_eframe", err_frame, exp_ef);
      chk("cmd_status", tx_data, st_byte(S_ERROR));
      cs_n = 1'b1;
      tick(1);
      smp();
      chk("cmd_idle", state_o, S_IDLE);
   endtask

   task automatic do_clear(input int d);
      cs_n = 1'b0;
      tick(1);
      send(8'hC3, 1'b0);
      smp();
      chk("clr_state", state_o, S_CLEAR);
      chk("clr_req", buf_clear, 1);
      tick(d);
      chk("clr_hold", buf_clear, 1);
      buf_clear_done = 1'b1;
      smp();
      chk("clr_drop", buf_clear, 0);
      tick(1);
      buf_clear_done = 1'b0;
      exp_rv = 1'b0; exp_et = 1'b0; exp_ef = 1'b0; exp_ec = 1'b0;
      smp();
      chk("clr_wait", state_o, S_WAIT_CS);
      chk("clr_flags", {result_valid, err_timeout, err_frame, err_cksum}, 0);
      cs_n = 1'b1;
      tick(1);
      smp();
      chk("clr_idle", state_o, S_IDLE);
   endtask

   task automatic mid_reset(input bit in_clear);
      cs_n = 1'b0;
      tick(1);
      send(in_clear ? 8'hC3 : 8'hA5, 1'b0);
      if (!in_clear) begin
         send(8'($urandom), 1'b0);
         send(8'($urandom), 1'b0);
      end
      chk("rst_pre_clr", buf_clear, in_clear);
      rst = 1'b1;
      #2;
      exp_rv = 1'b0; exp_et = 1'b0; exp_ef = 1'b0; exp_ec = 1'b0;
      exp_class = '0;
      chk("rst_state", state_o, S_IDLE);
      chk("rst_tx", tx_data, 0);
      chk("rst_outs", {buf_we, buf_clear, infer_start, result_valid,
                       err_timeout, err_frame, err_cksum}, 0);
      tick(1);
      rst = 1'b0;
      cs_n = 1'b1;
      tick(1);
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      buf_clear_done = 1'b0; infer_done = 1'b0; infer_class = '0;
      exp_rv = 1'b0; exp_et = 1'b0; exp_ef = 1'b0; exp_ec = 1'b0; exp_class = '0;
      start_cnt = 0;
      #12;
      chk("reset_state", state_o, S_IDLE);
      chk("reset_tx", tx_data, 0);
      chk("reset_outs", {buf_we, buf_addr, buf_wdata, buf_clear, infer_start,
                         result_valid, err_timeout, err_frame, err_cksum}, 0);
      rst = 1'b0;
      tick(2);

      full_load(1'b0, 1'b0);
      read_result();
      short_load($urandom_range(1, NB - 1));
      do_clear(5);
      to_load($urandom_range(1, NB - 1));
      cmd_bad(8'h11);
      read_result();
      full_load(1'b1, 1'b0);
      full_load(1'b0, CK);
      read_result();
      mid_reset(1'b0);
      read_result();
      cmd_bad(8'h00);
      mid_reset(1'b1);

      for (int it = 0; it < 10; it++) begin
         case ($urandom_range(0, 5))
            0: full_load(1'($urandom_range(0, 1)), CK && ($urandom_range(0, 1) == 1));
            1: read_result();
            2: short_load($urandom_range(1, NB - 1));
            3: to_load($urandom_range(1, NB - 1));
            4: begin
               do b = 8'($urandom);
               while (b == 8'hA5 || b == 8'h5A || b == 8'hC3);
               cmd_bad(b);
            end
            default: do_clear($urandom_range(1, 6));
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
